// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch slice: reset/chip-enable
// encodings, bus widths, the buffered {pc,inst} entry and the PC increment.
package pc_fetch_unit_pkg;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic        CHIP_ENABLE   = 1'b1;
  localparam logic        CHIP_DISABLE  = 1'b0;
  localparam int          INST_ADDR_W   = 32;
  localparam int          INST_W        = 32;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_ADDR = 32'h0000_0000;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  // One fetch-buffer slot: the instruction word tagged with its own address.
  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

  // Sequential PC step; wraps modulo 2^32.
  function automatic inst_addr_t pc_incr(input inst_addr_t pc);
    return pc + inst_addr_t'(4);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_fetch_buf.sv
// fetch_buf: DEPTH-entry synchronous FIFO of {pc,inst} entries.
// Pointers wrap at DEPTH (power of two); flush clears both pointers and count.
// The head output holds its last shown value while the FIFO is empty.
module fetch_buf
  import pc_fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       din,
  output fetch_entry_t       dout,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem [DEPTH];
  fetch_entry_t     head_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Entry storage write.
  // NOTE: the storage array is deliberately not reset; every slot is qualified
  // by count, so only the pointers and count need a reset value.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; reset and flush both empty the buffer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Remember the last presented head so an empty buffer shows a stable value.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) head_q <= '{pc: ZERO_WORD, inst: ZERO_WORD};
    else                   head_q <= dout;
  end

  // Head selection: live entry when occupied, otherwise the held value.
  always_comb begin
    // NOTE: combinational outputs get a default first so no path infers a latch.
    dout = head_q;
    if (count != '0) dout = mem[rd_ptr];
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC, drives the instruction ROM, buffers {pc,inst}
// pairs in fetch_buf and presents them to ID with a valid/ready handshake.
// A redirect from ID flushes the buffer and reloads the PC.
// Optional build macro FETCH_MISALIGN_EN: a misaligned redirect target is loaded
// as-is and raises a sticky fetch_fault_o that halts further fetching.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_ADDR,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        fetch_fault_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  inst_addr_t       pc;
  inst_addr_t       target;
  logic             halt;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     entry_in;

`ifdef FETCH_MISALIGN_EN
  // Sticky fault on a redirect to a non-word-aligned target; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE)                                   fetch_fault_o <= 1'b0;
    else if (branch_flag_i && branch_target_address_i[1:0] != 2'b00) fetch_fault_o <= 1'b1;
  end

  assign target = branch_target_address_i;
  assign halt   = fetch_fault_o;
`else
  // Without fault support the target is simply word-aligned.
  assign target        = branch_target_address_i & ~inst_addr_t'(3);
  assign halt          = 1'b0;
  assign fetch_fault_o = 1'b0;
`endif

  // Handshake control: a redirect suppresses both consumption and capture.
  always_comb begin
    pop  = id_valid_o & id_ready_i & ~branch_flag_i;
    push = rom_ce_o & ~branch_flag_i & ~halt & ((count != CNT_W'(DEPTH)) | pop);
  end

  // ROM enable comes up on the first edge out of reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) rom_ce_o <= CHIP_DISABLE;
    else                   rom_ce_o <= CHIP_ENABLE;
  end

  // PC: redirect wins, otherwise step only when the current fetch is captured.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) pc <= RESET_PC;
    else if (branch_flag_i) pc <= target;
    else if (push)          pc <= pc_incr(pc);
  end

  assign rom_addr_o = pc;
  assign entry_in   = '{pc: pc, inst: rom_inst_i};

  fetch_buf #(.DEPTH(DEPTH)) u_fetch_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (branch_flag_i),
    .din   (entry_in),
    .dout  (head),
    .count (count)
  );

  assign id_valid_o = (count != '0);
  assign id_pc_o    = head.pc;
  assign id_inst_o  = head.inst;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a per-cycle vector table on a default
// instance plus a hand sequence on an instance with RESET_PC near the top of
// the address space. The ROM returns 32'h1000_0000 + word index.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: default parameters.
  logic        rst, rom_ce, br, ready, valid, fault;
  logic [31:0] rom_addr, rom_inst, target, id_pc, id_inst;

  // Instance 2: RESET_PC = FFFF_FFF8.
  logic        rst2, rom_ce2, valid2, fault2;
  logic [31:0] rom_addr2, rom_inst2, id_pc2, id_inst2;

  function automatic logic [31:0] rom_data(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  assign rom_inst  = rom_data(rom_addr);
  assign rom_inst2 = rom_data(rom_addr2);

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .rom_ce_o(rom_ce), .rom_addr_o(rom_addr),
    .rom_inst_i(rom_inst), .branch_flag_i(br), .branch_target_address_i(target),
    .id_valid_o(valid), .id_ready_i(ready), .id_pc_o(id_pc), .id_inst_o(id_inst),
    .fetch_fault_o(fault)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .rom_ce_o(rom_ce2), .rom_addr_o(rom_addr2),
    .rom_inst_i(rom_inst2), .branch_flag_i(1'b0), .branch_target_address_i(32'h0),
    .id_valid_o(valid2), .id_ready_i(1'b1), .id_pc_o(id_pc2), .id_inst_o(id_inst2),
    .fetch_fault_o(fault2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One row = inputs applied for one cycle + outputs expected in that cycle.
  typedef struct {
    logic        rst;
    logic        ready;
    logic        br;
    logic [31:0] target;
    logic        ce;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input logic b, input logic [31:0] tgt,
                     input logic ce, input logic [31:0] a, input logic v,
                     input logic [31:0] p, input logic [31:0] i, input logic f);
    vec_t x;
    x = '{rst: r, ready: rdy, br: b, target: tgt, ce: ce, addr: a,
          valid: v, pc: p, inst: i, fault: f};
    vecs.push_back(x);
  endtask

  logic [31:0] got_pc   [3];
  logic [31:0] got_inst [3];
  int          got;

  initial begin
    //   rst rdy br target        ce addr          v  id_pc         id_inst        fault
    // Reset, then streaming at one instruction per cycle.
    add(1, 1, 0, 32'h0,          0, 32'h0000_0000, 0, 32'h0,        32'h0,         0);
    add(0, 1, 0, 32'h0,          0, 32'h0000_0000, 0, 32'h0,        32'h0,         0);
    add(0, 1, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,        32'h0,         0);
    add(0, 1, 0, 32'h0,          1, 32'h0000_0004, 1, 32'h0,        32'h1000_0000, 0);
    add(0, 1, 0, 32'h0,          1, 32'h0000_0008, 1, 32'h4,        32'h1000_0001, 0);
    // Reset mid-stream, then ID stalls for five cycles.
    add(1, 0, 0, 32'h0,          1, 32'h0000_000C, 1, 32'h8,        32'h1000_0002, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0000_0000, 0, 32'h0,        32'h0,         0);
    add(0, 0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,        32'h0,         0);
    add(0, 0, 0, 32'h0,          1, 32'h0000_0004, 1, 32'h0,        32'h1000_0000, 0);
    add(0, 0, 0, 32'h0,          1, 32'h0000_0008, 1, 32'h0,        32'h1000_0000, 0);
    add(0, 0, 0, 32'h0,          1, 32'h0000_0008, 1, 32'h0,        32'h1000_0000, 0);
    add(0, 0, 0, 32'h0,          1, 32'h0000_0008, 1, 32'h0,        32'h1000_0000, 0);
    // Release: 0,4,8 in order; full buffer with pop keeps pushing.
    add(0, 1, 0, 32'h0,          1, 32'h0000_0008, 1, 32'h0,        32'h1000_0000, 0);
    add(0, 1, 0, 32'h0,          1, 32'h0000_000C, 1, 32'h4,        32'h1000_0001, 0);
    // Redirect to 0x40 while full: head 8 shown but not consumed.
    add(0, 1, 1, 32'h40,         1, 32'h0000_0010, 1, 32'h8,        32'h1000_0002, 0);
    add(0, 1, 0, 32'h0,          1, 32'h0000_0040, 0, 32'h8,        32'h1000_0002, 0);
    add(0, 1, 0, 32'h0,          1, 32'h0000_0044, 1, 32'h40,       32'h1000_0010, 0);
    add(0, 1, 0, 32'h0,          1, 32'h0000_0048, 1, 32'h44,       32'h1000_0011, 0);
    // Fill to two entries, then reset with the buffer full.
    add(0, 0, 0, 32'h0,          1, 32'h0000_004C, 1, 32'h48,       32'h1000_0012, 0);
    add(1, 0, 0, 32'h0,          1, 32'h0000_0050, 1, 32'h48,       32'h1000_0012, 0);
    add(0, 1, 0, 32'h0,          0, 32'h0000_0000, 0, 32'h0,        32'h0,         0);
    // Redirect to misaligned 0x42.
    add(0, 1, 1, 32'h42,         1, 32'h0000_0000, 0, 32'h0,        32'h0,         0);
`ifdef FETCH_MISALIGN_EN
    add(0, 1, 0, 32'h0,          1, 32'h0000_0042, 0, 32'h0,        32'h0,         1);
    add(0, 1, 0, 32'h0,          1, 32'h0000_0042, 0, 32'h0,        32'h0,         1);
    add(0, 1, 0, 32'h0,          1, 32'h0000_0042, 0, 32'h0,        32'h0,         1);
`else
    add(0, 1, 0, 32'h0,          1, 32'h0000_0040, 0, 32'h0,        32'h0,         0);
    add(0, 1, 0, 32'h0,          1, 32'h0000_0044, 1, 32'h40,       32'h1000_0010, 0);
    add(0, 1, 0, 32'h0,          1, 32'h0000_0048, 1, 32'h44,       32'h1000_0011, 0);
`endif

    rst = 1'b1; ready = 1'b1; br = 1'b0; target = 32'h0;
    rst2 = 1'b1;
    @(posedge clk);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst; ready = vecs[k].ready; br = vecs[k].br; target = vecs[k].target;
      #1;
      check($sformatf("v%0d rom_ce", k),   {31'b0, rom_ce}, {31'b0, vecs[k].ce});
      check($sformatf("v%0d rom_addr", k), rom_addr,        vecs[k].addr);
      check($sformatf("v%0d id_valid", k), {31'b0, valid},  {31'b0, vecs[k].valid});
      check($sformatf("v%0d id_pc", k),    id_pc,           vecs[k].pc);
      check($sformatf("v%0d id_inst", k),  id_inst,         vecs[k].inst);
      check($sformatf("v%0d fault", k),    {31'b0, fault},  {31'b0, vecs[k].fault});
    end

    // Wrap-around instance: reset state, then collect the first three deliveries.
    @(negedge clk);
    check("wrap reset addr",  rom_addr2,         32'hFFFF_FFF8);
    check("wrap reset ce",    {31'b0, rom_ce2},  32'h0);
    check("wrap reset valid", {31'b0, valid2},   32'h0);
    rst2 = 1'b0;
    got  = 0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      @(negedge clk);
      #1;
      if (valid2) begin
        got_pc[got]   = id_pc2;
        got_inst[got] = id_inst2;
        got++;
      end
    end
    check("wrap delivered count", got, 3);
    if (got == 3) begin
      check("wrap pc0",   got_pc[0],   32'hFFFF_FFF8);
      check("wrap inst0", got_inst[0], 32'h4FFF_FFFE);
      check("wrap pc1",   got_pc[1],   32'hFFFF_FFFC);
      check("wrap inst1", got_inst[1], 32'h4FFF_FFFF);
      check("wrap pc2",   got_pc[2],   32'h0000_0000);
      check("wrap inst2", got_inst[2], 32'h1000_0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
